uart_receiver: RTL



---
 rtl/uart_receiver_if.sv | 43 ++++
 rtl/uart_receiver.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_receiver_if
// Bundles the serial-side inputs and the received-word outputs of the UART
// receiver so they travel as one port.
//   rx_in         : asynchronous serial line, idle high
//   baud_tick     : single-cycle pulse at baud * OVERSAMPLE
//   data_out      : last received word, LSB = first data bit
//   data_valid    : one-cycle strobe, data_out valid in that cycle
//   framing_error : one-cycle strobe, stop bit sampled low
//   rx_busy       : high whenever the receiver is not idle
// Handshake: data_valid / framing_error are qualifier strobes with no ready
// return path; the consumer must capture data_out in the strobe cycle or at
// least before the next frame completes.
// Modports: slave = receiver, master = line driver / consumer.
// ---------------------------------------------------------------------------
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_in;
  logic                 baud_tick;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 framing_error;
  logic                 rx_busy;

  modport slave (
    input  rx_in,
    input  baud_tick,
    output data_out,
    output data_valid,
    output framing_error,
    output rx_busy
  );

  modport master (
    output rx_in,
    output baud_tick,
    input  data_out,
    input  data_valid,
    input  framing_error,
    input  rx_busy
  );
endinterface

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// Oversampled 8N1-style UART receive stage (LSB first, idle high). The line
// is synchronised, then sampled only on baud_tick cycles. A received word is
// presented on data_out with a one-cycle data_valid strobe; a low stop bit
// gives a one-cycle framing_error strobe and the block then waits for the
// line to return high.
// Ports:
//   clk_in    : system clock
//   rst_n_in  : asynchronous active-low reset
//   bus       : uart_receiver_if.slave (rx_in, baud_tick, data_out,
//               data_valid, framing_error, rx_busy)
//   state_dbg : current FSM state encoding (IDLE=0 START=1 DATA=2 STOP=3
//               WAIT_IDLE=4)
// Optional feature: define UART_RX_MAJORITY_VOTE_EN to take each bit as the
// 2-of-3 majority of ticks SP-1, SP, SP+1, decided at SP+1. Undefined: a
// single sample at tick SP.
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  uart_receiver_if.slave bus,
  output logic [2:0]   state_dbg
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] SP_T   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_T = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_B = BW'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] DEC_T  = CW'(OVERSAMPLE / 2);
`else
  localparam logic [CW-1:0] DEC_T  = SP_T;
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t                state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   rx_s;
  logic                   samp_bit;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic                   vote_a;
  logic                   vote_b;
`endif

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign state_dbg = state;

  // Bit value used at the decision tick.
  always_comb begin
    samp_bit = rx_s;
`ifdef UART_RX_MAJORITY_VOTE_EN
    samp_bit = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state             <= IDLE;
      sync_q            <= '1;
      tick_cnt          <= '0;
      bit_cnt           <= '0;
      shift_q           <= '0;
      bus.data_out      <= '0;
      bus.data_valid    <= 1'b0;
      bus.framing_error <= 1'b0;
      bus.rx_busy       <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote_a            <= 1'b1;
      vote_b            <= 1'b1;
`endif
    end else begin
      sync_q            <= {sync_q[SYNC_STAGES-2:0], bus.rx_in};
      bus.data_valid    <= 1'b0;
      bus.framing_error <= 1'b0;

      if (bus.baud_tick) begin
`ifdef UART_RX_MAJORITY_VOTE_EN
        if (tick_cnt == SP_T - 1'b1) vote_a <= rx_s;
        if (tick_cnt == SP_T)        vote_b <= rx_s;
`endif
        tick_cnt <= (tick_cnt == LAST_T) ? '0 : tick_cnt + 1'b1;

        case (state)
          IDLE: begin
            if (!rx_s) begin
              // The detecting tick is tick 0 of the start bit.
              state       <= START;
              tick_cnt    <= CW'(1);
              bus.rx_busy <= 1'b1;
            end else begin
              tick_cnt <= '0;
            end
          end

          START: begin
            if (tick_cnt == DEC_T && samp_bit) begin
              // Start bit gone by mid-bit: treat as a glitch.
              state       <= IDLE;
              tick_cnt    <= '0;
              bus.rx_busy <= 1'b0;
            end else if (tick_cnt == LAST_T) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end

          DATA: begin
            if (tick_cnt == DEC_T)
              shift_q <= {samp_bit, shift_q[DATA_BITS-1:1]};
            if (tick_cnt == LAST_T) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_B) state <= STOP;
            end
          end

          STOP: begin
            // Leave at mid-stop-bit so a back-to-back start edge is caught.
            if (tick_cnt == DEC_T) begin
              bus.data_out <= shift_q;
              tick_cnt     <= '0;
              if (samp_bit) begin
                bus.data_valid <= 1'b1;
                bus.rx_busy    <= 1'b0;
                state          <= IDLE;
              end else begin
                bus.framing_error <= 1'b1;
                state             <= WAIT_IDLE;
              end
            end
          end

          WAIT_IDLE: begin
            tick_cnt <= '0;
            if (rx_s) begin
              state       <= IDLE;
              bus.rx_busy <= 1'b0;
            end
          end

          default: begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bus.rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
